// File: rtl/pdm_mic_capture.sv
// PDM mic clock, ones-count decimator, sample FIFO and Wishbone register window.
// Define PDM_MIC_IRQ_EN to build the FIFO-level interrupt; otherwise irq_o is 0.
`ifndef MIC_START
`define MIC_START 16'h0100
`endif

module pdm_mic_capture #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = `MIC_START,
  parameter int CLK_DIV = 32,
  parameter int DECIMATION = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int IRQ_LEVEL = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] adr_i,
  input  logic [7:0]               dat_i,
  output logic [7:0]               dat_o,
  input  logic                     we_i,
  input  logic                     sel_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  output logic                     ack_o,
  input  logic [2:0]               cti_i,
  output logic                     mic_clk_o,
  input  logic                     mic_data_i,
  output logic                     irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DECIMATION);
  localparam int OW = BW + 1;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] DIV_HALF = 8'(CLK_DIV / 2);
  localparam logic [7:0] MID = 8'(DECIMATION / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DECIMATION - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCUM, PUSH} dec_t;

  logic [ADDRESS_WIDTH-1:0] off_full;
  logic       accept;
  logic [1:0] req_off;
  logic       req_we;
  logic [1:0] req_dat;
  logic       wr_ctrl, clr, rd_data;
  logic       en;

  assign off_full = adr_i - BASE_ADDRESS;
  assign accept = cyc_i & stb_i & sel_i & ~ack_o
                & (off_full < ADDRESS_WIDTH'(4));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o   <= 1'b0;
      req_off <= '0;
      req_we  <= 1'b0;
      req_dat <= '0;
    end else begin
      ack_o <= accept;
      if (accept) begin
        req_off <= off_full[1:0];
        req_we  <= we_i;
        req_dat <= dat_i[1:0];
      end
    end
  end

  // Register side effects commit in the ack cycle.
  assign wr_ctrl = ack_o & req_we & (req_off == 2'd0);
  assign clr = wr_ctrl & req_dat[1];
  assign rd_data = ack_o & ~req_we & (req_off == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) en <= 1'b0;
    else if (wr_ctrl) en <= req_dat[0];
  end

  logic [7:0] div, div_next;
  logic       tick;
  logic [1:0] sync;

  always_comb begin
    div_next = 8'd0;
    if (en && !clr)
      div_next = (div == DIV_LAST) ? 8'd0 : div + 8'd1;
  end

  assign tick = en & (div == DIV_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div       <= 8'd0;
      mic_clk_o <= 1'b0;
      sync      <= 2'b00;
    end else begin
      div       <= div_next;
      mic_clk_o <= (div_next >= DIV_HALF);
      sync      <= {sync[0], mic_data_i};
    end
  end

  dec_t          state;
  logic [BW-1:0] bits;
  logic [OW-1:0] ones;
  logic [7:0]    sample;
  logic          push_req;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      bits  <= '0;
      ones  <= '0;
    end else if (clr || !en) begin
      state <= IDLE;
      bits  <= '0;
      ones  <= '0;
    end else begin
      unique case (state)
        IDLE: state <= ACCUM;
        ACCUM: begin
          if (tick) begin
            ones <= ones + OW'(sync[1]);
            bits <= bits + BW'(1);
            if (bits == BIT_LAST) state <= PUSH;
          end
        end
        PUSH: begin
          state <= ACCUM;
          bits  <= '0;
          ones  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sample = 8'(ones) - MID;
  assign push_req = (state == PUSH) & ~clr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt, cnt_next;
  logic          full, empty, pop, push_ok, ovf;

  assign full = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign pop = rd_data & ~empty;
  // A pop in the push cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_req & (~full | pop);

  always_comb begin
    cnt_next = cnt + CW'(push_ok) - CW'(pop);
    if (clr) cnt_next = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (clr) begin
        wptr <= '0;
        rptr <= '0;
        ovf  <= 1'b0;
      end else begin
        wptr <= wptr + AW'(push_ok);
        rptr <= rptr + AW'(pop);
        if (push_req && full && !pop) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= sample;
  end

`ifdef PDM_MIC_IRQ_EN
  localparam logic [CW-1:0] IRQ_C = CW'(IRQ_LEVEL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_o <= 1'b0;
    else irq_o <= (cnt_next >= IRQ_C);
  end
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    dat_o = 8'h00;
    if (ack_o && !req_we) begin
      unique case (req_off)
        2'd0: dat_o = {7'b0, en};
        2'd1: dat_o = {5'b0, ovf, full, empty};
        2'd2: dat_o = 8'(cnt);
        2'd3: dat_o = empty ? 8'h00 : mem[rptr];
        default: dat_o = 8'h00;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{cti_i, dat_i[7:2], DATA_WIDTH[0], IRQ_LEVEL[0]};

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Directed bench for pdm_mic_capture: bus, decimation levels, FIFO flags, irq.
`ifndef MIC_START
`define MIC_START 16'h0100
`endif

module tb_pdm_mic_capture;

  localparam logic [15:0] BASE = `MIC_START;
`ifdef PDM_MIC_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adr = '0;
  logic [7:0]  dati = '0;
  logic [7:0]  dato;
  logic        we = 1'b0;
  logic        sel = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        ack;
  logic        mic_clk;
  logic        mic_data;
  logic        irq;

  always #5 clk = ~clk;

  pdm_mic_capture dut (
    .clk_i(clk),
    .rst_i(rst),
    .adr_i(adr),
    .dat_i(dati),
    .dat_o(dato),
    .we_i(we),
    .sel_i(sel),
    .stb_i(stb),
    .cyc_i(cyc),
    .ack_o(ack),
    .cti_i(3'b000),
    .mic_clk_o(mic_clk),
    .mic_data_i(mic_data),
    .irq_o(irq)
  );

  // Pattern source: bit n is presented after the n-th mic clock fall.
  int   falls = 0;
  int   base = 0;
  int   n_rel;
  logic use_pat = 1'b0;
  logic alt = 1'b0;
  logic mic_const = 1'b0;

  always @(negedge mic_clk) falls = falls + 1;

  assign n_rel = falls - base;
  assign mic_data = !use_pat ? mic_const
                  : alt ? n_rel[0]
                  : ((n_rel % 64) < (8 + 3 * (n_rel / 64)));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [15:0] a, input logic w,
                     input logic [7:0] wd, output logic [7:0] rd);
    logic got;
    got = 1'b0;
    rd = 8'h5a;
    @(negedge clk);
    adr = a; we = w; dati = wd;
    cyc = 1'b1; stb = 1'b1; sel = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        rd = dato;
        got = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; sel = 1'b0; we = 1'b0;
    chk("bus_ack", got, 1);
  endtask

  task automatic rd(input string tag, input logic [1:0] off,
                    input logic [7:0] exp);
    logic [7:0] v;
    bus(BASE + 16'(off), 1'b0, 8'h00, v);
    chk(tag, v, exp);
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] val);
    logic [7:0] v;
    bus(BASE + 16'(off), 1'b1, val, v);
  endtask

  task automatic wait_falls(input int target, input string tag);
    int lim;
    lim = (target - n_rel) * 40 + 200;
    for (int i = 0; i < lim && n_rel < target; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, n_rel >= target, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int cnt;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_dat", dato, 0);
    chk("rst_mclk", mic_clk, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk) rst = 1'b0;

    // Full scale ones and first-push latency.
    mic_const = 1'b1;
    wr(2'd0, 8'h01);
    repeat (2038) @(posedge clk);
    rd("lvl_early", 2'd2, 8'd0);
    repeat (12) @(posedge clk);
    rd("lvl_first", 2'd2, 8'd1);
    rd("stat_one", 2'd1, 8'h00);

    // Disable mid-frame keeps FIFO, drops partial sample.
    repeat (1000) @(posedge clk);
    wr(2'd0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("dis_mclk", mic_clk, 0);
    rd("lvl_kept", 2'd2, 8'd1);
    mic_const = 1'b0;
    wr(2'd0, 8'h01);
    repeat (2100) @(posedge clk);
    rd("lvl_two", 2'd2, 8'd2);
    rd("data_p32", 2'd3, 8'h20);
    rd("data_m32", 2'd3, 8'he0);
    rd("stat_emp", 2'd1, 8'h01);

    // Alternating stream.
    wr(2'd0, 8'h02);
    repeat (2) @(posedge clk);
    alt = 1'b1;
    base = falls;
    use_pat = 1'b1;
    wr(2'd0, 8'h01);
    repeat (2100) @(posedge clk);
    rd("data_alt", 2'd3, 8'h00);

    // Reset in the middle of an access while running.
    @(negedge clk);
    adr = BASE + 16'd2;
    cyc = 1'b1; stb = 1'b1; sel = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_ack", ack, 0);
    chk("mrst_dat", dato, 0);
    chk("mrst_mclk", mic_clk, 0);
    chk("mrst_irq", irq, 0);
    cyc = 1'b0; stb = 1'b0; sel = 1'b0;
    @(negedge clk) rst = 1'b0;
    rd("mrst_ctrl", 2'd0, 8'h00);
    rd("mrst_stat", 2'd1, 8'h01);

    // Idle with EN=0.
    use_pat = 1'b0;
    mic_const = 1'b1;
    cnt = 0;
    repeat (10000) begin
      @(posedge clk); #1;
      if (mic_clk) cnt++;
    end
    chk("idle_mclk", cnt, 0);
    rd("idle_lvl", 2'd2, 8'h00);

    // Empty read, ignored writes, ack width, window decode.
    rd("empty_data", 2'd3, 8'h00);
    @(posedge clk); #1;
    chk("ack_pulse", ack, 0);
    rd("empty_lvl", 2'd2, 8'h00);
    wr(2'd2, 8'h55);
    wr(2'd1, 8'hff);
    rd("ro_lvl", 2'd2, 8'h00);
    rd("ro_stat", 2'd1, 8'h01);
    @(negedge clk);
    adr = BASE + 16'd4;
    cyc = 1'b1; stb = 1'b1; sel = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ack) cnt++;
    end
    chk("oow_ack", cnt, 0);
    adr = BASE + 16'd3;
    sel = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ack) cnt++;
    end
    chk("nosel_ack", cnt, 0);
    cyc = 1'b0; stb = 1'b0;

    // Overflow with distinct per-sample values (ones = 8 + 3j).
    wr(2'd0, 8'h02);
    repeat (2) @(posedge clk);
    alt = 1'b0;
    base = falls;
    use_pat = 1'b1;
    wr(2'd0, 8'h01);
    wait_falls(512, "wait_s7");
    chk("irq_pre", irq, 0);
    @(posedge clk); #1;
    chk("irq_rise", irq, IRQ_ON);

    // Pop lands in the PUSH cycle of sample 16 at LEVEL=16.
    wait_falls(1087, "wait_s16");
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mic_clk) break;
    end
    repeat (15) @(posedge clk);
    bus(BASE + 16'd3, 1'b0, 8'h00, v);
    chk("sim_data", v, 8'he8);
    rd("sim_lvl", 2'd2, 8'd16);
    rd("sim_stat", 2'd1, 8'h02);

    wait_falls(1152, "wait_s17");
    repeat (3) @(posedge clk);
    rd("ovf_lvl", 2'd2, 8'd16);
    rd("ovf_stat", 2'd1, 8'h06);
    wr(2'd0, 8'h00);

    for (int k = 1; k <= 16; k++) begin
      rd($sformatf("drain_%0d", k), 2'd3, 8'(8 + 3 * k - 32));
      @(posedge clk); #1;
      chk($sformatf("irq_%0d", k), irq, IRQ_ON & ((16 - k) >= 8));
    end
    rd("drain_stat", 2'd1, 8'h05);
    rd("drain_lvl", 2'd2, 8'h00);
    wr(2'd0, 8'h03);
    rd("clr_stat", 2'd1, 8'h01);
    rd("clr_ctrl", 2'd0, 8'h01);
    wr(2'd0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
